ssemi_adc_decimator_csr_arbiter: RTL and testbench
==================================================

Name: ssemi_adc_decimator_csr_arbiter

Overview:
Two-requester round-robin arbiter and transaction sequencer for the ADC decimator CSR port. Requester 0 is the host register bus; requester 1 is the on-chip calibration/coefficient loader. The block serialises single-beat read/write transactions onto the decimator's CSR write (valid/ready) and read (ready/valid) interfaces and returns a response with an error flag. It sits between the system interconnect and the decimator top.

Parameters:
ADDR_MAX, 8'h3F, highest legal CSR address; any address above it returns an error response with no downstream access.
TIMEOUT_CYCLES, 64, number of cycles to wait for a downstream handshake before aborting (timeout feature only).
ERR_RDATA, 32'hDEAD_BEEF, response data returned on any error response.

Ports:
i_clk  in  1  clock; the single clock of the block.
i_rst  in  1  reset, asynchronous, active-high.
i_reqN_valid  in  1  request valid, N=0,1.
i_reqN_wr  in  1  1 = write, 0 = read.
i_reqN_addr  in  8  CSR address.
i_reqN_wdata  in  32  write data.
o_reqN_ready  out  1  request accepted this cycle.
o_reqN_rsp_valid  out  1  one-cycle response pulse.
o_reqN_rsp_data  out  32  read data; 0 for an OK write; ERR_RDATA on error.
o_reqN_rsp_err  out  1  response error (bad address or timeout).
o_csr_wr_valid  out  1  downstream write valid.
o_csr_addr  out  8  downstream address, shared by read and write.
o_csr_wr_data  out  32  downstream write data.
i_csr_wr_ready  in  1  downstream write ready.
o_csr_rd_ready  out  1  downstream read request/accept.
i_csr_rd_data  in  32  downstream read data.
i_csr_rd_valid  in  1  downstream read valid.
o_busy  out  1  high whenever the state is not IDLE.
o_grant_id  out  1  requester that owns the current transaction.

Behaviour:
- Reset: all outputs are 0, state = IDLE, round-robin pointer = 0 (requester 0 favoured).
- Reset asserted mid-transaction aborts immediately. No response is issued and downstream valid/ready drop asynchronously.
- States: IDLE, WRITE, READ, RESP.
- IDLE, grant selection:
  - The grant is combinational from the valids and the pointer.
  - o_reqN_ready = (state == IDLE) and grant == N.
  - Both valid: the pointer-favoured requester wins. One valid: it wins regardless of pointer.
- IDLE, on handshake:
  - Latch wr/addr/wdata/id and set o_grant_id.
  - The pointer moves to the other requester.
  - addr > ADDR_MAX: go to RESP with err=1.
  - Otherwise go to WRITE if wr=1, else READ.
- WRITE:
  - o_csr_wr_valid=1; addr/data come from the latch and are stable until the handshake.
  - On i_csr_wr_ready: go to RESP with data 0, err 0.
- READ:
  - o_csr_rd_ready=1; addr is stable.
  - On i_csr_rd_valid: capture i_csr_rd_data and go to RESP, err 0.
  - A rd_valid arriving in any other state is ignored.
- RESP:
  - o_reqG_rsp_valid=1 for exactly one cycle, where G is the latched id.
  - rsp_data/rsp_err are registered and held until the next response.
  - Next state is always IDLE.
- Latency: accept at cycle T; downstream valid/ready at T+1; a handshake at T+k gives the response at T+k+1. Minimum is 2 cycles from accept to response.
- Throughput: at most one transaction per 3 cycles (accept, access, response). The block never accepts a request while busy.
- The non-granted requester's valid may stay high indefinitely; it is served next.
- Requester-side fields are sampled only at the accept cycle; later changes have no effect.

Optional Feature:
Macro SSEMI_CSR_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WRITE/READ and increments each cycle without a handshake.
  - When the count reaches TIMEOUT_CYCLES-1 without a handshake, downstream valid/ready are dropped and the block goes to RESP with err=1, data=ERR_RDATA.
  - A handshake in that same cycle takes priority: normal response, no error.
- Not defined: no counter; WRITE/READ wait indefinitely for the handshake.

Test Plan:
- Req0 write addr 0x04, data 0x0000_0040, wr_ready held high → o_csr_wr_valid at T+1; rsp0 pulse at T+2 with data 0, err 0; o_busy high T+1..T+2.
- Req1 read addr 0x10, rd_valid asserted 3 cycles after rd_ready with data 0x1234_5678 → rsp1_data=0x1234_5678, err 0; o_csr_addr stable at 0x10 throughout.
- Both requesters valid continuously, 4 transactions → grants alternate 0,1,0,1 after reset; no requester is starved.
- Req0 write addr 0x40 (ADDR_MAX=0x3F) → no o_csr_wr_valid; rsp0 err=1, data 0xDEAD_BEEF, two cycles after accept.
- With SSEMI_CSR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, wr_ready stuck low → wr_valid high exactly 8 cycles, then rsp err=1. Without the macro, wr_valid stays high with no response.
- i_rst pulsed while in READ → outputs 0 immediately; afterwards a req1-only request is accepted normally and the pointer is back at 0.

Source files
------------

// File: rtl/ssemi_adc_decimator_csr_arbiter.sv
// Two-requester round-robin arbiter / sequencer for the ADC decimator CSR port.
// Optional downstream handshake timeout: define SSEMI_CSR_ARB_TIMEOUT_EN.
module ssemi_adc_decimator_csr_arbiter #(
    parameter logic [7:0]  ADDR_MAX       = 8'h3F,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic        i_req0_wr,
    input  logic [7:0]  i_req0_addr,
    input  logic [31:0] i_req0_wdata,
    output logic        o_req0_ready,
    output logic        o_req0_rsp_valid,
    output logic [31:0] o_req0_rsp_data,
    output logic        o_req0_rsp_err,
    input  logic        i_req1_valid,
    input  logic        i_req1_wr,
    input  logic [7:0]  i_req1_addr,
    input  logic [31:0] i_req1_wdata,
    output logic        o_req1_ready,
    output logic        o_req1_rsp_valid,
    output logic [31:0] o_req1_rsp_data,
    output logic        o_req1_rsp_err,
    output logic        o_csr_wr_valid,
    output logic [7:0]  o_csr_addr,
    output logic [31:0] o_csr_wr_data,
    input  logic        i_csr_wr_ready,
    output logic        o_csr_rd_ready,
    input  logic [31:0] i_csr_rd_data,
    input  logic        i_csr_rd_valid,
    output logic        o_busy,
    output logic        o_grant_id
);

    // A zero timeout would make the abort compare meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        id_q, id_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bad_q, bad_d;

    logic [31:0] rsp0_data_q, rsp1_data_q;
    logic        rsp0_err_q, rsp1_err_q;

    logic        rsp_load;
    logic [31:0] rsp_data_n;
    logic        rsp_err_n;

    logic        any_valid;
    logic        gnt;
    logic        sel_wr;
    logic [7:0]  sel_addr;
    logic [31:0] sel_wdata;
    logic        tmo;

`ifdef SSEMI_CSR_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Wait counter for the pending downstream handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Grant: pointer breaks ties, a lone requester always wins.
    always_comb begin
        any_valid = i_req0_valid | i_req1_valid;
        gnt       = (i_req0_valid & i_req1_valid) ? ptr_q : i_req1_valid;
        sel_wr    = gnt ? i_req1_wr    : i_req0_wr;
        sel_addr  = gnt ? i_req1_addr  : i_req0_addr;
        sel_wdata = gnt ? i_req1_wdata : i_req0_wdata;
    end

    // Next-state and response capture for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        bad_d      = bad_q;
        rsp_load   = 1'b0;
        rsp_data_n = '0;
        rsp_err_n  = 1'b0;
`ifdef SSEMI_CSR_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ptr_d   = ~gnt;
                    id_d    = gnt;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    // Bad addresses still spend one cycle in the access
                    // state (with downstream strobes masked) so every
                    // response arrives at least two cycles after accept.
                    bad_d   = (sel_addr > ADDR_MAX);
                    state_d = sel_wr ? WRITE : READ;
`ifdef SSEMI_CSR_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WRITE: begin
                if (bad_q) begin
                    state_d    = RESP;
                    rsp_load   = 1'b1;
                    rsp_data_n = ERR_RDATA;
                    rsp_err_n  = 1'b1;
                end else if (i_csr_wr_ready) begin
                    state_d    = RESP;
                    rsp_load   = 1'b1;
                end else if (tmo) begin
                    state_d    = RESP;
                    rsp_load   = 1'b1;
                    rsp_data_n = ERR_RDATA;
                    rsp_err_n  = 1'b1;
                end else begin
`ifdef SSEMI_CSR_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            READ: begin
                if (bad_q) begin
                    state_d    = RESP;
                    rsp_load   = 1'b1;
                    rsp_data_n = ERR_RDATA;
                    rsp_err_n  = 1'b1;
                end else if (i_csr_rd_valid) begin
                    state_d    = RESP;
                    rsp_load   = 1'b1;
                    rsp_data_n = i_csr_rd_data;
                end else if (tmo) begin
                    state_d    = RESP;
                    rsp_load   = 1'b1;
                    rsp_data_n = ERR_RDATA;
                    rsp_err_n  = 1'b1;
                end else begin
`ifdef SSEMI_CSR_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and transaction latch registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
        end
    end

    // Per-requester response data/err, held until that requester's next response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rsp0_data_q <= '0;
            rsp0_err_q  <= 1'b0;
            rsp1_data_q <= '0;
            rsp1_err_q  <= 1'b0;
        end else if (rsp_load) begin
            if (id_q) begin
                rsp1_data_q <= rsp_data_n;
                rsp1_err_q  <= rsp_err_n;
            end else begin
                rsp0_data_q <= rsp_data_n;
                rsp0_err_q  <= rsp_err_n;
            end
        end
    end

    // Outputs decoded from registered state; strobes drop with async reset.
    always_comb begin
        o_req0_ready     = (state_q == IDLE) & any_valid & ~gnt;
        o_req1_ready     = (state_q == IDLE) & any_valid & gnt;
        o_req0_rsp_valid = (state_q == RESP) & ~id_q;
        o_req1_rsp_valid = (state_q == RESP) & id_q;
        o_req0_rsp_data  = rsp0_data_q;
        o_req0_rsp_err   = rsp0_err_q;
        o_req1_rsp_data  = rsp1_data_q;
        o_req1_rsp_err   = rsp1_err_q;
        o_csr_wr_valid   = (state_q == WRITE) & ~bad_q;
        o_csr_rd_ready   = (state_q == READ) & ~bad_q;
        o_csr_addr       = addr_q;
        o_csr_wr_data    = wdata_q;
        o_busy           = (state_q != IDLE);
        o_grant_id       = id_q;
    end

endmodule

// File: tb/tb_ssemi_adc_decimator_csr_arbiter.sv
// Directed self-checking bench for ssemi_adc_decimator_csr_arbiter.
// Timeout expectations follow SSEMI_CSR_ARB_TIMEOUT_EN (TIMEOUT_CYCLES=8).
module tb_ssemi_adc_decimator_csr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v0 = 0, wr0 = 0, v1 = 0, wr1 = 0;
    logic [7:0]  a0 = 0, a1 = 0;
    logic [31:0] d0 = 0, d1 = 0;
    logic        rdy0, rdy1, rv0, rv1, re0, re1;
    logic [31:0] rd0, rd1;
    logic        wvalid, rready, busy, gid;
    logic [7:0]  caddr;
    logic [31:0] cwdata;
    logic        wready = 0, rvalid = 0;
    logic [31:0] rdata = 0;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    ssemi_adc_decimator_csr_arbiter #(
        .ADDR_MAX       (8'h3F),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req0_valid     (v0),
        .i_req0_wr        (wr0),
        .i_req0_addr      (a0),
        .i_req0_wdata     (d0),
        .o_req0_ready     (rdy0),
        .o_req0_rsp_valid (rv0),
        .o_req0_rsp_data  (rd0),
        .o_req0_rsp_err   (re0),
        .i_req1_valid     (v1),
        .i_req1_wr        (wr1),
        .i_req1_addr      (a1),
        .i_req1_wdata     (d1),
        .o_req1_ready     (rdy1),
        .o_req1_rsp_valid (rv1),
        .o_req1_rsp_data  (rd1),
        .o_req1_rsp_err   (re1),
        .o_csr_wr_valid   (wvalid),
        .o_csr_addr       (caddr),
        .o_csr_wr_data    (cwdata),
        .i_csr_wr_ready   (wready),
        .o_csr_rd_ready   (rready),
        .i_csr_rd_data    (rdata),
        .i_csr_rd_valid   (rvalid),
        .o_busy           (busy),
        .o_grant_id       (gid)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // reset state
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_gid", gid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_addr", caddr, 0);
        chk("rst_wdata", cwdata, 0);
        chk("rst_rv0", rv0, 0);
        chk("rst_rd0", rd0, 0);
        chk("rst_re0", re0, 0);
        chk("rst_rv1", rv1, 0);
        chk("rst_rd1", rd1, 0);
        chk("rst_re1", re1, 0);
        chk("rst_rdy0", rdy0, 0);
        chk("rst_rdy1", rdy1, 0);
        rst = 1'b0;

        // req0 write 0x04 <= 0x40, wr_ready held high
        wready = 1; v0 = 1; wr0 = 1; a0 = 8'h04; d0 = 32'h40;
        #1;
        chk("w_rdy0", rdy0, 1);
        chk("w_rdy1", rdy1, 0);
        step();
        v0 = 0; d0 = 32'hFFFF_0000; a0 = 8'h3A;
        #1;
        chk("w_wvalid", wvalid, 1);
        chk("w_addr", caddr, 8'h04);
        chk("w_wdata", cwdata, 32'h40);
        chk("w_busy1", busy, 1);
        chk("w_gid", gid, 0);
        chk("w_rv0_early", rv0, 0);
        chk("w_rdy0_busy", rdy0, 0);
        step();
        chk("w_rv0", rv0, 1);
        chk("w_rd0", rd0, 0);
        chk("w_re0", re0, 0);
        chk("w_rv1", rv1, 0);
        chk("w_wvalid_off", wvalid, 0);
        chk("w_busy2", busy, 1);
        step();
        chk("w_idle", busy, 0);
        chk("w_rv0_pulse", rv0, 0);

        // req1 read 0x10, rd_valid three cycles after rd_ready
        wready = 0; v1 = 1; wr1 = 0; a1 = 8'h10;
        #1 chk("r_rdy1", rdy1, 1);
        step();
        v1 = 0; a1 = 8'h3E;
        chk("r_rready", rready, 1);
        chk("r_addr0", caddr, 8'h10);
        chk("r_gid", gid, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("r_rready_hold", rready, 1);
            chk("r_addr_hold", caddr, 8'h10);
            chk("r_rv1_early", rv1, 0);
        end
        step();
        chk("r_rready_last", rready, 1);
        rvalid = 1; rdata = 32'h1234_5678;
        step();
        rvalid = 0; rdata = 0;
        chk("r_rv1", rv1, 1);
        chk("r_rd1", rd1, 32'h1234_5678);
        chk("r_re1", re1, 0);
        chk("r_rv0", rv0, 0);
        step();
        // stray rd_valid while idle is ignored
        rvalid = 1; rdata = 32'hBAD0_BAD0;
        step();
        rvalid = 0; rdata = 0;
        chk("ign_busy", busy, 0);
        chk("ign_rv1", rv1, 0);
        chk("ign_rd1", rd1, 32'h1234_5678);

        // both requesters continuously valid: 0,1,0,1
        wready = 1;
        v0 = 1; wr0 = 1; a0 = 8'h01; d0 = 32'h11;
        v1 = 1; wr1 = 1; a1 = 8'h02; d1 = 32'h22;
        for (int t = 0; t < 4; t++) begin
            logic e;
            e = (t % 2) == 1;
            #1;
            chk("rr_rdy0", rdy0, !e);
            chk("rr_rdy1", rdy1, e);
            step();
            chk("rr_gid", gid, e);
            chk("rr_addr", caddr, e ? 8'h02 : 8'h01);
            step();
            chk("rr_rv0", rv0, !e);
            chk("rr_rv1", rv1, e);
            step();
        end
        v0 = 0; v1 = 0;

        // req0 write to 0x40: error, no downstream access
        v0 = 1; wr0 = 1; a0 = 8'h40; d0 = 32'h99;
        #1 chk("bw_rdy0", rdy0, 1);
        step();
        v0 = 0;
        chk("bw_wvalid", wvalid, 0);
        chk("bw_busy", busy, 1);
        chk("bw_rv0_early", rv0, 0);
        step();
        chk("bw_rv0", rv0, 1);
        chk("bw_re0", re0, 1);
        chk("bw_rd0", rd0, 32'hDEAD_BEEF);
        chk("bw_wvalid2", wvalid, 0);
        step();

        // req1 read from 0xFF: error, no rd_ready
        wready = 0; v1 = 1; wr1 = 0; a1 = 8'hFF;
        #1 chk("br_rdy1", rdy1, 1);
        step();
        v1 = 0;
        chk("br_rready", rready, 0);
        step();
        chk("br_rv1", rv1, 1);
        chk("br_re1", re1, 1);
        chk("br_rd1", rd1, 32'hDEAD_BEEF);
        step();

        // write with wr_ready stuck low
        v0 = 1; wr0 = 1; a0 = 8'h08; d0 = 32'h5555;
        #1 chk("to_rdy0", rdy0, 1);
        step();
        v0 = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!wvalid) break;
            n++;
            step();
        end
`ifdef SSEMI_CSR_ARB_TIMEOUT_EN
        chk("to_cycles", n, 8);
        chk("to_rv0", rv0, 1);
        chk("to_re0", re0, 1);
        chk("to_rd0", rd0, 32'hDEAD_BEEF);
        step();
`else
        chk("to_cycles", n, 40);
        chk("to_rv0_none", rv0, 0);
        chk("to_busy", busy, 1);
        wready = 1;
        step();
        wready = 0;
        chk("to_rv0", rv0, 1);
        chk("to_re0", re0, 0);
        chk("to_rd0", rd0, 0);
        step();
`endif
        chk("to_idle", busy, 0);

        // reset during READ
        v1 = 1; wr1 = 0; a1 = 8'h20;
        #1 chk("rs_rdy1", rdy1, 1);
        step();
        v1 = 0;
        chk("rs_rready", rready, 1);
        step();
        chk("rs_rready2", rready, 1);
        #1 rst = 1'b1;
        #1;
        chk("rs_rready_off", rready, 0);
        chk("rs_busy_off", busy, 0);
        chk("rs_gid_off", gid, 0);
        chk("rs_addr_off", caddr, 0);
        step();
        rst = 1'b0;
        chk("rs_rv1", rv1, 0);
        v0 = 1; wr0 = 0; a0 = 8'h00;
        v1 = 1;
        #1;
        chk("rs_ptr_rdy0", rdy0, 1);
        chk("rs_ptr_rdy1", rdy1, 0);
        v0 = 0;
        #1 chk("rs_rdy1_only", rdy1, 1);
        step();
        v1 = 0;
        chk("rs_gid", gid, 1);
        chk("rs_rready3", rready, 1);
        chk("rs_addr", caddr, 8'h20);
        rvalid = 1; rdata = 32'hA5A5_A5A5;
        step();
        rvalid = 0; rdata = 0;
        chk("rs_rv1_resp", rv1, 1);
        chk("rs_rd1", rd1, 32'hA5A5_A5A5);
        chk("rs_re1", re1, 0);
        step();
        chk("rs_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
